// File: rtl/ocp_pkg.sv
// ocp_pkg: shared types and constants for the OCP memory target.
//   mem_tgt_state_e  - target FSM state encoding (IDLE, WAIT, DONE)
//   MEM_TGT_MAX_WAIT - largest supported WAIT_STATES value
//   wait_cnt_t       - wait-state counter type, wide enough for MEM_TGT_MAX_WAIT
package ocp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_tgt_state_e;

    localparam int unsigned MEM_TGT_MAX_WAIT = 15;
    localparam int unsigned MEM_TGT_CNT_W    = 4;

    typedef logic [MEM_TGT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/ocp_mem_target_if.sv
// ocp_mem_target_if: memory-access request bus between the OCP bridge
// (master) and the memory target (slave).
//   mem_access_request/type/address/write_data - request from bridge
//   mem_read_data/access_complete/busy         - response from target
//   parity_inject/parity_error                 - only with OCP_MEM_PARITY_EN
interface ocp_mem_target_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  mem_access_request;
    logic                  mem_access_type;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_access_complete;
    logic                  mem_busy;
`ifdef OCP_MEM_PARITY_EN
    logic                  parity_inject;
    logic                  parity_error;
`endif

    modport master (
        output mem_access_request,
        output mem_access_type,
        output mem_address,
        output mem_write_data,
`ifdef OCP_MEM_PARITY_EN
        output parity_inject,
        input  parity_error,
`endif
        input  mem_read_data,
        input  mem_access_complete,
        input  mem_busy
    );

    modport slave (
        input  mem_access_request,
        input  mem_access_type,
        input  mem_address,
        input  mem_write_data,
`ifdef OCP_MEM_PARITY_EN
        input  parity_inject,
        output parity_error,
`endif
        output mem_read_data,
        output mem_access_complete,
        output mem_busy
    );

endinterface

// File: rtl/ocp_mem_array.sv
// ocp_mem_array: 2^ADDR_WIDTH x DATA_WIDTH storage, synchronous write,
// registered read, synchronous clear on reset.
// Optional macro OCP_MEM_PARITY_EN adds one stored parity bit per word and a
// registered parity-mismatch flag that pulses with each read.
//   clk, reset          - clock, synchronous active-high clear
//   we_i/waddr_i/wdata_i - write port (commits at the clock edge)
//   wpar_i              - parity bit stored with the write (parity build)
//   re_i/raddr_i        - read port; rdata_o loads on the edge, else holds
//   perr_o              - read parity mismatch, one cycle (parity build)
module ocp_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
`ifdef OCP_MEM_PARITY_EN
    input  logic                  wpar_i,
    output logic                  perr_o,
`endif
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage and read register; reset wipes the whole array.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

`ifdef OCP_MEM_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             perr_q;

    // Parity store; the error flag is a pulse, cleared on any non-read cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            if (we_i) begin
                par_q[waddr_i] <= wpar_i;
            end
            perr_q <= re_i && ((^mem_q[raddr_i]) != par_q[raddr_i]);
        end
    end

    assign perr_o = perr_q;
`endif

endmodule

// File: rtl/ocp_mem_target.sv
// ocp_mem_target: terminal memory target of the OCP slave datapath.
// Accepts one access at a time from the bridge, inserts WAIT_STATES wait
// cycles, then completes with a one-cycle mem_access_complete pulse.
// Optional macro OCP_MEM_PARITY_EN enables per-word parity with error
// injection (parity_inject) and read-time checking (parity_error).
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   bus   - ocp_mem_target_if.slave request/response bus
module ocp_mem_target
    import ocp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             reset,
    ocp_mem_target_if.slave  bus
);

    localparam bit NO_WAIT = (WAIT_STATES == 0);

    mem_tgt_state_e        state_q;
    wait_cnt_t             cnt_q;
    logic                  type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  complete_q;
    logic                  busy_q;

    logic                  accept_c;
    logic                  enter_done_c;
    logic                  rd_type_c;
    logic                  rd_en_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;
    logic                  wr_en_c;

    assign accept_c     = (state_q == IDLE) && bus.mem_access_request;
    assign enter_done_c = (accept_c && NO_WAIT) ||
                          ((state_q == WAIT) && (cnt_q == wait_cnt_t'(1)));

    // With no wait states the read happens on the accept edge, so the live
    // request fields are used; otherwise the latched copies are.
    assign rd_type_c = (state_q == IDLE) ? bus.mem_access_type : type_q;
    assign rd_addr_c = (state_q == IDLE) ? bus.mem_address     : addr_q;
    assign rd_en_c   = enter_done_c && !rd_type_c;

    // Write commits on the edge that ends DONE.
    assign wr_en_c = (state_q == DONE) && type_q;

`ifdef OCP_MEM_PARITY_EN
    logic inj_q;
    logic wr_par_c;

    assign wr_par_c = (^wdata_q) ^ inj_q;

    // Injection flag is captured alongside the rest of the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else if (accept_c) begin
            inj_q <= bus.parity_inject;
        end
    end
`endif

    // Access sequencer: request latch, wait counter, completion and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            type_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.mem_access_request) begin
                        type_q  <= bus.mem_access_type;
                        addr_q  <= bus.mem_address;
                        wdata_q <= bus.mem_write_data;
                        cnt_q   <= wait_cnt_t'(WAIT_STATES);
                        busy_q  <= 1'b1;
                        if (NO_WAIT) begin
                            state_q    <= DONE;
                            complete_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - wait_cnt_t'(1);
                    if (cnt_q == wait_cnt_t'(1)) begin
                        state_q    <= DONE;
                        complete_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_access_complete = complete_q;
    assign bus.mem_busy            = busy_q;

    ocp_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_en_c),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
`ifdef OCP_MEM_PARITY_EN
        .wpar_i  (wr_par_c),
        .perr_o  (bus.parity_error),
`endif
        .re_i    (rd_en_c),
        .raddr_i (rd_addr_c),
        .rdata_o (bus.mem_read_data)
    );

endmodule

// File: tb/tb_ocp_mem_target.sv
// Bench for ocp_mem_target: one instance with WAIT_STATES=2 (dut2) and one
// with WAIT_STATES=0 (dut0), sharing clock and reset.
module tb_ocp_mem_target;

    logic clk;
    logic reset;

    int checks;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ocp_mem_target_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if2 ();
    ocp_mem_target_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if0 ();

    ocp_mem_target #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    ocp_mem_target #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    typedef struct {
        logic [31:0] rd;
        logic        pe;
    } exp_t;

    typedef struct {
        int          which;
        logic        typ;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        inj;
        logic [31:0] exp_rd;
        logic        exp_pe;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic req, input logic typ,
                         input logic [4:0] a, input logic [31:0] d, input logic inj);
        if (which == 0) begin
            if0.mem_access_request = req;
            if0.mem_access_type    = typ;
            if0.mem_address        = a;
            if0.mem_write_data     = d;
`ifdef OCP_MEM_PARITY_EN
            if0.parity_inject      = inj;
`endif
        end else begin
            if2.mem_access_request = req;
            if2.mem_access_type    = typ;
            if2.mem_address        = a;
            if2.mem_write_data     = d;
`ifdef OCP_MEM_PARITY_EN
            if2.parity_inject      = inj;
`endif
        end
    endtask

    task automatic sample(input int which, output logic cmp, output logic busy,
                          output logic [31:0] rd, output logic pe);
        pe = 1'b0;
        if (which == 0) begin
            cmp  = if0.mem_access_complete;
            busy = if0.mem_busy;
            rd   = if0.mem_read_data;
`ifdef OCP_MEM_PARITY_EN
            pe   = if0.parity_error;
`endif
        end else begin
            cmp  = if2.mem_access_complete;
            busy = if2.mem_busy;
            rd   = if2.mem_read_data;
`ifdef OCP_MEM_PARITY_EN
            pe   = if2.parity_error;
`endif
        end
    endtask

    // One complete access: expected response queued at drive time, checked
    // against the completion cycle. perturb changes address/data during WAIT.
    task automatic do_access(input int which, input logic typ, input logic [4:0] a,
                             input logic [31:0] d, input logic inj,
                             input logic [31:0] exp_rd, input logic exp_pe,
                             input bit perturb);
        int   ws;
        int   n;
        bit   seen;
        exp_t e;
        logic cmp, busy, pe;
        logic [31:0] rd;
        ws   = (which == 0) ? 0 : 2;
        n    = 0;
        seen = 1'b0;
        e.rd = exp_rd;
        e.pe = exp_pe;
        sb.push_back(e);
        @(negedge clk);
        drive(which, 1'b1, typ, a, d, inj);
        @(posedge clk);
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            sample(which, cmp, busy, rd, pe);
            check("busy_in_flight", 32'(busy), 32'd1);
            if (perturb && n == 1) drive(which, 1'b1, typ, a ^ 5'h07, ~d, inj);
            if (cmp) seen = 1'b1;
        end
        drive(which, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0);
        e = sb.pop_front();
        if (!seen) begin
            check("complete_timeout", 32'd0, 32'd1);
        end else begin
            check("complete_latency", 32'(n), 32'(ws + 1));
            check("read_data", rd, e.rd);
`ifdef OCP_MEM_PARITY_EN
            check("parity_error", 32'(pe), 32'(e.pe));
`endif
            @(negedge clk);
            sample(which, cmp, busy, rd, pe);
            check("complete_one_cycle", 32'(cmp), 32'd0);
            check("busy_cleared", 32'(busy), 32'd0);
            check("read_data_held", rd, e.rd);
        end
    endtask

    initial begin
        logic cmp, busy, pe;
        logic [31:0] rd;
        checks = 0;
        fails  = 0;

        //                which typ  addr   wdata          inj   exp_rd         exp_pe
        vecs[0]  = '{2, 1'b0, 5'h07, 32'h0,         1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{2, 1'b1, 5'h1F, 32'hDEADBEEF,  1'b0, 32'h00000000, 1'b0};
        vecs[2]  = '{2, 1'b0, 5'h1F, 32'h0,         1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{2, 1'b1, 5'h0A, 32'h00001234,  1'b0, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{2, 1'b0, 5'h0A, 32'h0,         1'b0, 32'h00001234, 1'b0};
        vecs[5]  = '{2, 1'b0, 5'h1F, 32'h0,         1'b0, 32'hDEADBEEF, 1'b0};
        vecs[6]  = '{0, 1'b1, 5'h00, 32'h11111111,  1'b0, 32'h00000000, 1'b0};
        vecs[7]  = '{0, 1'b1, 5'h01, 32'h22222222,  1'b0, 32'h00000000, 1'b0};
        vecs[8]  = '{0, 1'b0, 5'h00, 32'h0,         1'b0, 32'h11111111, 1'b0};
        vecs[9]  = '{0, 1'b0, 5'h01, 32'h0,         1'b0, 32'h22222222, 1'b0};
        vecs[10] = '{0, 1'b1, 5'h00, 32'hCAFEF00D,  1'b0, 32'h22222222, 1'b0};
        vecs[11] = '{0, 1'b0, 5'h00, 32'h0,         1'b0, 32'hCAFEF00D, 1'b0};
        vecs[12] = '{2, 1'b1, 5'h02, 32'hA5A5A5A5,  1'b1, 32'hDEADBEEF, 1'b0};
        vecs[13] = '{2, 1'b0, 5'h02, 32'h0,         1'b0, 32'hA5A5A5A5, 1'b1};
        vecs[14] = '{2, 1'b1, 5'h06, 32'h0F0F0F0E,  1'b0, 32'hA5A5A5A5, 1'b0};
        vecs[15] = '{2, 1'b0, 5'h06, 32'h0,         1'b0, 32'h0F0F0F0E, 1'b0};

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0);
        drive(2, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w <= 2; w += 2) begin
            sample(w, cmp, busy, rd, pe);
            check("reset_complete", 32'(cmp), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_read_data", rd, 32'h0);
            check("reset_parity_error", 32'(pe), 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_access(vecs[i].which, vecs[i].typ, vecs[i].addr, vecs[i].wdata,
                      vecs[i].inj, vecs[i].exp_rd, vecs[i].exp_pe, 1'b0);
        end

        // Address/data changed during WAIT: latched values must be committed.
        do_access(2, 1'b1, 5'h03, 32'h0BADC0DE, 1'b0, 32'h0F0F0F0E, 1'b0, 1'b1);
        do_access(2, 1'b0, 5'h04, 32'h0, 1'b0, 32'h00000000, 1'b0, 1'b0);
        do_access(2, 1'b0, 5'h03, 32'h0, 1'b0, 32'h0BADC0DE, 1'b0, 1'b0);

        // Reset during WAIT of a write: aborted, no pulse, no commit.
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 5'h05, 32'h12345678, 1'b0);
        @(posedge clk);
        @(negedge clk);
        sample(2, cmp, busy, rd, pe);
        check("abort_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        drive(2, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sample(2, cmp, busy, rd, pe);
        check("abort_read_data_cleared", rd, 32'h0);
        check("abort_busy_cleared", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sample(2, cmp, busy, rd, pe);
            check("abort_no_complete", 32'(cmp), 32'd0);
        end
        do_access(2, 1'b0, 5'h05, 32'h0, 1'b0, 32'h00000000, 1'b0, 1'b0);
        do_access(2, 1'b0, 5'h1F, 32'h0, 1'b0, 32'h00000000, 1'b0, 1'b0);
        do_access(0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h00000000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
